result_completion_arbiter: RTL and testbench

- Shares the single completion port between the N per-reservation-station result producers (execution-unit result streams).
- Grants at most one result per cycle using rotating round-robin priority, so no station starves.
- Buffers granted results in a 2-entry registered output FIFO that absorbs downstream reject.
- Sits between the execution units and the completion/commit stage; honours the pipeline-wide flash.

---
 rtl/result_completion_arbiter.sv | 109 ++++++++++
 tb/tb_result_completion_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/result_completion_arbiter.sv
// Round-robin arbiter that funnels N result streams into one completion port
// through a 2-entry registered FIFO, with pipeline flash and stall counting.
module result_completion_arbiter #(
    parameter int unsigned NUM_Q = 7,
    parameter int unsigned MSG_W = 57,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clock,
    input  logic                     nreset,
    input  logic                     flash,
    input  logic [NUM_Q-1:0]         req_en,
    input  logic [NUM_Q*MSG_W-1:0]   req_msg,
    output logic [NUM_Q-1:0]         req_reject,
    output logic                     out_en,
    output logic [MSG_W-1:0]         out_msg,
    input  logic                     out_reject,
    output logic [CNT_W-1:0]         stall_cycles
);

    localparam int unsigned IDX_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_Q - 1);

    logic [MSG_W-1:0] msg_arr [NUM_Q];
    logic [MSG_W-1:0] fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             grant_valid;
    logic             pop;
    logic             space;

    for (genvar i = 0; i < NUM_Q; i++) begin : g_unpack
        assign msg_arr[i] = req_msg[i*MSG_W +: MSG_W];
    end

    assign out_en      = (count != 2'd0) & ~flash;
    assign out_msg     = fifo_mem[rd_ptr];
    assign pop         = out_en & ~out_reject;
    assign space       = (count < 2'd2) | pop;
    assign grant_valid = space & ~flash & grant_any;

    // First requester at or after the slot following the last grant, wrapping.
    always_comb begin
        logic [IDX_W-1:0] cand;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_Q; k++) begin
            cand = IDX_W'((32'(last_grant) + k) % NUM_Q);
            if (!grant_any && req_en[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_reject = '1;
        if (grant_valid) begin
            req_reject[grant_idx] = 1'b0;
        end
    end

    // FIFO control and round-robin pointer; flash drops everything queued.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            last_grant <= LAST_IDX;
        end else if (flash) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            last_grant <= LAST_IDX;
        end else begin
            if (grant_valid) begin
                wr_ptr     <= ~wr_ptr;
                last_grant <= grant_idx;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(grant_valid) - 2'(pop);
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else if (grant_valid) begin
            fifo_mem[wr_ptr] <= msg_arr[grant_idx];
        end
    end

    // Saturating count of cycles the head was offered but rejected.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            stall_cycles <= '0;
        end else if (out_en && out_reject && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_result_completion_arbiter.sv
// Randomized bench for result_completion_arbiter against a queue-based model.
module tb_result_completion_arbiter;

    localparam int unsigned NQ = 7;
    localparam int unsigned MW = 57;
    localparam int unsigned CW = 32;
    localparam longint unsigned SAT = (64'd1 << CW) - 64'd1;

    logic                clock = 1'b0;
    logic                nreset;
    logic                flash;
    logic [NQ-1:0]       req_en;
    logic [NQ*MW-1:0]    req_msg;
    logic [NQ-1:0]       req_reject;
    logic                out_en;
    logic [MW-1:0]       out_msg;
    logic                out_reject;
    logic [CW-1:0]       stall_cycles;

    logic [MW-1:0]       msgs [NQ];
    logic [MW-1:0]       mq [$];
    int                  lg;
    longint unsigned     m_stall;
    int unsigned         n_vec = 0;
    int unsigned         n_bad = 0;

    result_completion_arbiter #(.NUM_Q(NQ), .MSG_W(MW), .CNT_W(CW)) dut (
        .clock        (clock),
        .nreset       (nreset),
        .flash        (flash),
        .req_en       (req_en),
        .req_msg      (req_msg),
        .req_reject   (req_reject),
        .out_en       (out_en),
        .out_msg      (out_msg),
        .out_reject   (out_reject),
        .stall_cycles (stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        lg      = NQ - 1;
        m_stall = 0;
    endtask

    // One cycle: drive at negedge, compare just after, advance model at posedge.
    task automatic step(input logic [NQ-1:0] en, input logic rj, input logic fl);
        logic          exp_en;
        logic [NQ-1:0] exp_rej;
        int            g;
        int            idx;
        bit            gv;
        bit            popm;
        @(negedge clock);
        req_en     = en;
        out_reject = rj;
        flash      = fl;
        for (int i = 0; i < int'(NQ); i++) req_msg[i*MW +: MW] = msgs[i];
        #1;
        exp_en = (mq.size() != 0) && !fl;
        popm   = exp_en && !rj;
        g = -1;
        for (int k = 1; k <= int'(NQ); k++) begin
            idx = (lg + k) % int'(NQ);
            if (g < 0 && (((en >> idx) & NQ'(1)) != '0)) g = idx;
        end
        gv = ((mq.size() < 2) || popm) && !fl && (g >= 0);
        exp_rej = gv ? ~(NQ'(1) << g) : '1;
        check("out_en", 64'(out_en), 64'(exp_en));
        if (exp_en) check("out_msg", 64'(out_msg), 64'(mq[0]));
        check("req_reject", 64'(req_reject), 64'(exp_rej));
        check("stall_cycles", 64'(stall_cycles), 64'(m_stall[CW-1:0]));
        @(posedge clock);
        if (exp_en && rj && m_stall != SAT) m_stall++;
        if (fl) begin
            mq.delete();
            lg = NQ - 1;
        end else begin
            if (popm) void'(mq.pop_front());
            if (gv) begin
                mq.push_back(msgs[g]);
                lg = g;
            end
        end
    endtask

    initial begin
        nreset     = 1'b0;
        flash      = 1'b0;
        req_en     = '0;
        req_msg    = '0;
        out_reject = 1'b0;
        for (int i = 0; i < int'(NQ); i++) msgs[i] = MW'(i);
        model_reset();
        #12;
        check("rst_out_en", 64'(out_en), 64'd0);
        check("rst_out_msg", 64'(out_msg), 64'd0);
        check("rst_req_reject", 64'(req_reject), 64'h7F);
        check("rst_stall", 64'(stall_cycles), 64'd0);
        @(negedge clock);
        nreset = 1'b1;

        // Idle after reset, then full contention, then two-stream alternation.
        for (int c = 0; c < 5; c++) step('0, 1'b0, 1'b0);
        for (int c = 0; c < 14; c++) step(7'h7F, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) step(7'b0000101, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) step('0, 1'b0, 1'b0);

        // Downstream back-pressure fills the FIFO, then drain with pushes.
        for (int c = 0; c < 4; c++) step(7'h01, 1'b1, 1'b0);
        #1;
        check("stall_after_reject", 64'(stall_cycles), 64'd3);
        for (int c = 0; c < 4; c++) step(7'h01, 1'b0, 1'b0);

        // Fill, flash, then a single request on stream 3.
        for (int c = 0; c < 3; c++) step(7'h01, 1'b1, 1'b0);
        step(7'h7F, 1'b0, 1'b1);
        step(7'h08, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) step('0, 1'b0, 1'b0);

        // Random traffic with occasional reject and flash.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < int'(NQ); i++) msgs[i] = MW'({$urandom(), $urandom()});
            step(NQ'($urandom()), ($urandom() % 4) == 0, ($urandom() % 32) == 0);
        end

        // Asynchronous reset with one entry queued.
        step('0, 1'b0, 1'b1);
        step(7'h01, 1'b1, 1'b0);
        @(negedge clock);
        req_en = '0;
        #2 nreset = 1'b0;
        #1;
        check("async_out_en", 64'(out_en), 64'd0);
        check("async_stall", 64'(stall_cycles), 64'd0);
        check("async_req_reject", 64'(req_reject), 64'h7F);
        model_reset();
        @(negedge clock);
        nreset = 1'b1;
        for (int c = 0; c < 8; c++) step(7'h7F, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
